layer_host_seq: RTL
===================

Name: layer_host_seq

Overview:
Synthesizable host-side sequencer that drives the lenet layer handshake in hardware. It issues the one-cycle `enable` start pulse and, for each of six parameter phases (l0_pre, l0_post, l1, l2_pre, l2_post, l3), requests a DRAM parameter load from the DMA/loader. After each load it pulses `rdy_data`, then waits for the accelerator's `done_one_layer`, or for `done` after the final phase. It sits between the system controller and lenet, replacing the bench-side pattern feeder.

Parameters:
NUM_PHASES, 6, number of parameter-load phases per inference
PHASE_W, 3, width of phase index
TIMEOUT_CYCLES, 4000000, watchdog limit per wait state
TMO_W, 22, width of watchdog counter

Ports:
clk  input  1  system clock, rising edge
srstn  input  1  asynchronous active-low reset
start  input  1  begin one inference; sampled only in IDLE
abort  input  1  return to IDLE from any state, next cycle
load_req  output  1  parameter load request; held high until load_done
load_phase  output  PHASE_W  phase being loaded (0..NUM_PHASES-1), valid while load_req high
load_done  input  1  loader finished; accepted only while load_req high
enable  output  1  one-cycle start pulse to lenet
rdy_data  output  1  one-cycle "parameters ready" pulse to lenet
done_one_layer  input  1  lenet layer-complete indication
done  input  1  lenet inference complete
busy  output  1  high in every state except IDLE and ERROR
finished  output  1  one-cycle pulse on inference completion
err  output  1  sticky watchdog flag; cleared by start-from-ERROR, abort or reset

Behaviour:
- All outputs are registered. Reset values are 0; state resets to IDLE, phase to 0, watchdog to 0, dol_q to 0.
- States: IDLE, EN_PULSE, LOAD, RDY, WAIT_LAYER, WAIT_DONE, FIN, ERROR.
- IDLE: when start=1, go to EN_PULSE. enable is high for exactly the one cycle spent in EN_PULSE, which is the cycle after start is sampled.
- EN_PULSE → LOAD, with phase=0.
- LOAD: load_req=1 and load_phase=phase.
  - load_done is honoured on any cycle load_req is high, including the first. It moves the FSM to RDY and drops load_req on the next cycle.
  - load_done outside LOAD is ignored.
- RDY: rdy_data=1 for exactly one cycle.
  - If phase < NUM_PHASES-1, go to WAIT_LAYER.
  - Otherwise go to WAIT_DONE.
- WAIT_LAYER: acts only on a rising edge of done_one_layer (done_one_layer=1 and registered previous value dol_q=0). A level held over from the prior layer never advances the FSM.
  - On the edge, phase increments and the FSM goes to LOAD.
- WAIT_DONE: done=1 → FIN.
- FIN: finished=1 for one cycle, then IDLE.
- Watchdog:
  - Cleared on every state change.
  - Counts in LOAD, WAIT_LAYER and WAIT_DONE.
  - Reaching TIMEOUT_CYCLES-1 without the awaited event → ERROR: err=1, load_req=0.
  - If the event and the timeout occur in the same cycle, the event wins.
- ERROR: stays until abort (→ IDLE, err cleared) or start (clears err, → EN_PULSE).
- abort: highest priority. From any state the next state is IDLE, load_req/enable/rdy_data are deasserted, phase and watchdog are cleared.
- start outside IDLE/ERROR is ignored, with no restart.
- Reset mid-operation: outputs drop asynchronously to 0. The loader and lenet must tolerate a load_req withdrawn mid-transfer.
- phase never exceeds NUM_PHASES-1; no wrap.

Test Plan:
- Nominal: start pulse, load_done 3 cycles after each load_req, done_one_layer pulse 20 cycles after each rdy_data, done 20 cycles after the 6th rdy_data.
  - Expect: 1 enable exactly one cycle after start; load_phase sequence 0,1,2,3,4,5; 6 rdy_data pulses; 5 layer waits; finished one cycle after done; busy low afterward.
- Stale level: hold done_one_layer=1 continuously from the first rdy_data.
  - Expect: FSM stays in WAIT_LAYER with phase=0 until done_one_layer drops and rises again.
- Watchdog: TIMEOUT_CYCLES=16; never assert load_done.
  - Expect: err=1 and load_req=0 exactly 16 cycles after load_req rose; busy=0; a later start clears err and emits enable.
- Same-cycle load_done: assert load_done on the first cycle load_req=1.
  - Expect: rdy_data on the next cycle; load_req high for exactly 1 cycle.
- Abort in WAIT_LAYER at phase 3: abort pulse.
  - Expect: next cycle IDLE, busy=0, no rdy_data/load_req; a subsequent start restarts at phase 0.
- Async reset during LOAD phase 2.
  - Expect: load_req, enable, rdy_data, busy and err all 0 immediately, without waiting for a clock edge; after release, start gives a full phase 0..5 sequence.

Source files
------------

// File: rtl/layer_host_seq.sv
// ============================================================================
// Module   : layer_host_seq
// Brief    : Host-side sequencer driving the lenet enable / parameter-load /
//            rdy_data handshake over six parameter phases, with a watchdog.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module layer_host_seq #(
  parameter int NUM_PHASES     = 6,
  parameter int PHASE_W        = 3,
  parameter int TIMEOUT_CYCLES = 4000000,
  parameter int TMO_W          = 22
) (
  input  logic               clk,
  input  logic               srstn,
  input  logic               start,
  input  logic               abort,
  output logic               load_req,
  output logic [PHASE_W-1:0] load_phase,
  input  logic               load_done,
  output logic               enable,
  output logic               rdy_data,
  input  logic               done_one_layer,
  input  logic               done,
  output logic               busy,
  output logic               finished,
  output logic               err
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_EN_PULSE   = 3'd1,
    S_LOAD       = 3'd2,
    S_RDY        = 3'd3,
    S_WAIT_LAYER = 3'd4,
    S_WAIT_DONE  = 3'd5,
    S_FIN        = 3'd6,
    S_ERROR      = 3'd7
  } state_t;

  localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(NUM_PHASES - 1);
  localparam logic [PHASE_W-1:0] PHASE_ONE  = PHASE_W'(1);
  localparam logic [TMO_W-1:0]   TMO_LAST   = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMO_W-1:0]   TMO_ONE    = TMO_W'(1);

  state_t             state_q, state_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [TMO_W-1:0]   wdog_q, wdog_d;
  logic               dol_q;
  logic               dol_rise;
  logic               timeout;

  logic               load_req_q, enable_q, rdy_data_q, busy_q, finished_q, err_q;
  logic [PHASE_W-1:0] load_phase_q;

  // Only a fresh edge counts, so a level left over from the previous layer is ignored.
  assign dol_rise = done_one_layer & ~dol_q;
  assign timeout  = (wdog_q == TMO_LAST);

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    case (state_q)
      S_IDLE:       if (start) state_d = S_EN_PULSE;
      S_EN_PULSE: begin
        state_d = S_LOAD;
        phase_d = '0;
      end
      S_LOAD: begin
        if (load_done)    state_d = S_RDY;
        else if (timeout) state_d = S_ERROR;
      end
      S_RDY:        state_d = (phase_q < LAST_PHASE) ? S_WAIT_LAYER : S_WAIT_DONE;
      S_WAIT_LAYER: begin
        if (dol_rise) begin
          state_d = S_LOAD;
          phase_d = phase_q + PHASE_ONE;
        end else if (timeout) begin
          state_d = S_ERROR;
        end
      end
      S_WAIT_DONE: begin
        if (done)         state_d = S_FIN;
        else if (timeout) state_d = S_ERROR;
      end
      S_FIN:        state_d = S_IDLE;
      S_ERROR:      if (start) state_d = S_EN_PULSE;
      default:      state_d = S_IDLE;
    endcase
    if (abort) begin
      state_d = S_IDLE;
      phase_d = '0;
    end
  end

  // Watchdog restarts on every state change and only runs in the wait states.
  always_comb begin
    wdog_d = '0;
    if (!abort && (state_d == state_q) &&
        ((state_q == S_LOAD) || (state_q == S_WAIT_LAYER) || (state_q == S_WAIT_DONE)))
      wdog_d = wdog_q + TMO_ONE;
  end

  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      state_q      <= S_IDLE;
      phase_q      <= '0;
      wdog_q       <= '0;
      dol_q        <= 1'b0;
      load_req_q   <= 1'b0;
      load_phase_q <= '0;
      enable_q     <= 1'b0;
      rdy_data_q   <= 1'b0;
      busy_q       <= 1'b0;
      finished_q   <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      wdog_q       <= wdog_d;
      dol_q        <= done_one_layer;
      load_req_q   <= (state_d == S_LOAD);
      load_phase_q <= (state_d == S_LOAD) ? phase_d : '0;
      enable_q     <= (state_d == S_EN_PULSE);
      rdy_data_q   <= (state_d == S_RDY);
      busy_q       <= (state_d != S_IDLE) && (state_d != S_ERROR);
      finished_q   <= (state_d == S_FIN);
      err_q        <= (state_d == S_ERROR);
    end
  end

  assign load_req   = load_req_q;
  assign load_phase = load_phase_q;
  assign enable     = enable_q;
  assign rdy_data   = rdy_data_q;
  assign busy       = busy_q;
  assign finished   = finished_q;
  assign err        = err_q;

endmodule

`default_nettype wire
